// File: rtl/cyclo_pkg.sv
// Shared types and constants for the FAM channelizer
// exponential-phase sequencing blocks.
package cyclo_pkg;

  localparam int PHASE_ADDR_W = 10;
  localparam int NP_LOG2_BASE = 4;
  localparam int NP_LOG2_MAX  = 10;

  localparam logic [2:0] NFFT_16   = 3'b000;
  localparam logic [2:0] NFFT_32   = 3'b001;
  localparam logic [2:0] NFFT_64   = 3'b010;
  localparam logic [2:0] NFFT_128  = 3'b011;
  localparam logic [2:0] NFFT_256  = 3'b100;
  localparam logic [2:0] NFFT_512  = 3'b101;
  localparam logic [2:0] NFFT_1024 = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Selects 110 and 111 both map to the 1024-point frame.
  function automatic logic [3:0] np_log2_of(
    input logic [2:0] sel
  );
    logic [2:0] s;
    s = (sel > NFFT_1024) ? NFFT_1024 : sel;
    return 4'(NP_LOG2_BASE) + {1'b0, s};
  endfunction

endpackage

// File: rtl/exp_phase_sequencer_phase_accumulator.sv
// Running phase for the current block: acc walks by blk_inc
// per sample, blk_inc grows by step at every block boundary.
module phase_accumulator
  import cyclo_pkg::*;
#(
  parameter int ADDR_W = PHASE_ADDR_W
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_step,
  input  logic              i_clr,
  input  logic              i_advance_sample,
  input  logic              i_advance_block,
  output logic [ADDR_W-1:0] o_acc
);

  logic [ADDR_W-1:0] r_acc;
  logic [ADDR_W-1:0] r_blk_inc;

  always_ff @(posedge clock) begin
    if (i_reset || i_clr) begin
      r_acc     <= '0;
      r_blk_inc <= '0;
    end else if (i_advance_block) begin
      r_acc     <= '0;
      r_blk_inc <= r_blk_inc + i_step;
    end else if (i_advance_sample) begin
      r_acc <= r_acc + r_blk_inc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/exp_phase_sequencer.sv
// Sample/block sequencer producing exp(-i2pi*m*p*L/Np) table
// addresses for each accepted FFT output beat.
module exp_phase_sequencer
  import cyclo_pkg::*;
#(
  parameter int P_MAX  = 64,
  parameter int ADDR_W = PHASE_ADDR_W
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [2:0]                   i_NFFT_sel,
  input  logic [3:0]                   i_L_log2,
  input  logic [$clog2(P_MAX+1)-1:0]   i_num_blocks,
  input  logic                         i_s_tvalid,
  input  logic                         i_s_tlast,
  output logic                         o_s_tready,
  output logic [ADDR_W-1:0]            o_addr,
  output logic                         o_addr_valid,
  output logic [9:0]                   o_m,
  output logic [$clog2(P_MAX)-1:0]     o_p,
  output logic                         o_block_done,
  output logic                         o_run_done,
  output logic                         o_busy,
  output logic                         o_err_tlast
);

  localparam int NB_W = $clog2(P_MAX+1);
  localparam int P_W  = $clog2(P_MAX);

  seq_state_t        r_state;
  logic [3:0]        r_np_log2;
  logic [NB_W-1:0]   r_nblk;
  logic [ADDR_W-1:0] r_step;
  logic [9:0]        r_m;
  logic [P_W-1:0]    r_p;

  logic [3:0]        w_np_log2;
  logic [5:0]        w_shamt;
  logic [ADDR_W-1:0] w_step;
  logic [9:0]        w_np_m1;
  logic              w_start;
  logic              w_take;
  logic              w_m_last;
  logic              w_eob;
  logic              w_last_blk;
  logic [ADDR_W-1:0] w_acc;

  // Step is L*2^ADDR_W/Np; shifting past the width gives 0 (L >= Np).
  assign w_np_log2 = np_log2_of(i_NFFT_sel);
  assign w_shamt   = 6'(i_L_log2) + 6'(ADDR_W) - 6'(w_np_log2);
  assign w_step    = {{(ADDR_W-1){1'b0}}, 1'b1} << w_shamt;

  assign w_np_m1    = ~(10'h3FF << r_np_log2);
  assign w_m_last   = (r_m == w_np_m1);
  assign w_last_blk = ({{(NB_W-P_W){1'b0}}, r_p} == r_nblk - NB_W'(1));

  assign o_s_tready = (r_state == RUN) & i_enable;
  assign o_busy     = (r_state == RUN);

  assign w_start = (r_state == IDLE) & i_start & i_enable & ~i_abort;
  assign w_take  = i_s_tvalid & o_s_tready & ~i_abort;
  assign w_eob   = w_take & (w_m_last | i_s_tlast);

  phase_accumulator #(
    .ADDR_W (ADDR_W)
  ) u_acc (
    .clock            (clock),
    .i_reset          (i_reset),
    .i_step           (r_step),
    .i_clr            (w_start),
    .i_advance_sample (w_take & ~w_eob),
    .i_advance_block  (w_eob),
    .o_acc            (w_acc)
  );

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_np_log2    <= 4'(NP_LOG2_BASE);
      r_nblk       <= '0;
      r_step       <= '0;
      r_m          <= '0;
      r_p          <= '0;
      o_addr       <= '0;
      o_addr_valid <= 1'b0;
      o_m          <= '0;
      o_p          <= '0;
      o_block_done <= 1'b0;
      o_run_done   <= 1'b0;
      o_err_tlast  <= 1'b0;
    end else begin
      o_addr_valid <= 1'b0;
      o_block_done <= 1'b0;
      o_run_done   <= (r_state == DONE) & ~i_abort;
      if (i_abort) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_start) begin
              r_np_log2   <= w_np_log2;
              r_nblk      <= i_num_blocks;
              r_step      <= w_step;
              r_m         <= '0;
              r_p         <= '0;
              o_err_tlast <= 1'b0;
              r_state     <= RUN;
            end
          end
          RUN: begin
            if (w_take) begin
              o_addr_valid <= 1'b1;
              o_addr       <= w_acc;
              o_m          <= r_m;
              o_p          <= r_p;
              o_block_done <= w_eob;
              // Misplaced or missing tlast still closes the block.
              if (i_s_tlast != w_m_last)
                o_err_tlast <= 1'b1;
              if (w_eob) begin
                r_m <= '0;
                r_p <= r_p + P_W'(1);
                if (w_last_blk)
                  r_state <= DONE;
              end else begin
                r_m <= r_m + 10'd1;
              end
            end
          end
          DONE: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exp_phase_sequencer.sv
// Directed bench for exp_phase_sequencer with hand-derived
// addresses (m*p*step mod 1024) checked by immediate assertions.
module tb_exp_phase_sequencer;

  logic       clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b1;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [2:0] i_NFFT_sel = 3'd0;
  logic [3:0] i_L_log2 = 4'd2;
  logic [6:0] i_num_blocks = 7'd1;
  logic       i_s_tvalid = 1'b0;
  logic       i_s_tlast = 1'b0;
  logic       o_s_tready;
  logic [9:0] o_addr;
  logic       o_addr_valid;
  logic [9:0] o_m;
  logic [5:0] o_p;
  logic       o_block_done;
  logic       o_run_done;
  logic       o_busy;
  logic       o_err_tlast;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  exp_phase_sequencer dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_NFFT_sel   (i_NFFT_sel),
    .i_L_log2     (i_L_log2),
    .i_num_blocks (i_num_blocks),
    .i_s_tvalid   (i_s_tvalid),
    .i_s_tlast    (i_s_tlast),
    .o_s_tready   (o_s_tready),
    .o_addr       (o_addr),
    .o_addr_valid (o_addr_valid),
    .o_m          (o_m),
    .o_p          (o_p),
    .o_block_done (o_block_done),
    .o_run_done   (o_run_done),
    .o_busy       (o_busy),
    .o_err_tlast  (o_err_tlast)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_addr"}, int'(o_addr), 0);
    chk({tag, "_valid"}, int'(o_addr_valid), 0);
    chk({tag, "_m"}, int'(o_m), 0);
    chk({tag, "_p"}, int'(o_p), 0);
    chk({tag, "_bdone"}, int'(o_block_done), 0);
    chk({tag, "_rdone"}, int'(o_run_done), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_err"}, int'(o_err_tlast), 0);
    chk({tag, "_tready"}, int'(o_s_tready), 0);
  endtask

  task automatic beat(input bit last, input int em, input int ep,
                      input int ea, input bit ed);
    i_s_tvalid = 1'b1;
    i_s_tlast  = last;
    tick();
    i_s_tvalid = 1'b0;
    i_s_tlast  = 1'b0;
    chk("valid", int'(o_addr_valid), 1);
    chk("addr", int'(o_addr), ea);
    chk("m", int'(o_m), em);
    chk("p", int'(o_p), ep);
    chk("bdone", int'(o_block_done), int'(ed));
  endtask

  task automatic start(input logic [2:0] sel, input logic [3:0] ll,
                       input int nb);
    i_NFFT_sel   = sel;
    i_L_log2     = ll;
    i_num_blocks = 7'(nb);
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_start", int'(o_busy), 1);
    chk("tready_start", int'(o_s_tready), 1);
  endtask

  task automatic done_seq();
    chk("rdone_early", int'(o_run_done), 0);
    chk("busy_done", int'(o_busy), 0);
    tick();
    chk("rdone", int'(o_run_done), 1);
    chk("valid_idle", int'(o_addr_valid), 0);
    tick();
    chk("rdone_pulse", int'(o_run_done), 0);
  endtask

  task automatic run_blocks(input int np, input int stepv,
                            input int nb, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      for (int m = 0; m < np; m++) begin
        if (gaps) begin
          int idle;
          idle = int'($urandom_range(0, 2));
          repeat (idle) begin
            tick();
            chk("valid_gap", int'(o_addr_valid), 0);
          end
          if (b == 1 && m == 10) begin
            i_enable   = 1'b0;
            i_s_tvalid = 1'b1;
            repeat (5) begin
              tick();
              chk("tready_dis", int'(o_s_tready), 0);
              chk("valid_dis", int'(o_addr_valid), 0);
            end
            i_enable   = 1'b1;
            i_s_tvalid = 1'b0;
          end
        end
        beat(m == np - 1, m, b, (m * b * stepv) % 1024, m == np - 1);
      end
    end
    done_seq();
  endtask

  initial begin
    repeat (3) tick();
    zeros("rst");
    i_reset = 1'b0;
    tick();
    zeros("idle");

    // Np=16, L=4, P=2: block 1 walks 0,256,512,768
    start(3'd0, 4'd2, 2);
    run_blocks(16, 256, 2, 1'b0);
    chk("err_t1", int'(o_err_tlast), 0);

    // Np=1024, L=256, P=3: block 2 alternates 0,512
    start(3'd6, 4'd8, 3);
    run_blocks(1024, 256, 3, 1'b0);
    chk("err_t2", int'(o_err_tlast), 0);

    // Np=32, L=8, P=4 with gaps and an enable drop
    start(3'd1, 4'd3, 4);
    run_blocks(32, 256, 4, 1'b1);
    chk("err_t3", int'(o_err_tlast), 0);

    // Early tlast at m=9 resyncs to the next block
    start(3'd0, 4'd2, 2);
    for (int m = 0; m < 10; m++) begin
      beat(m == 9, m, 0, 0, m == 9);
      chk("err_early", int'(o_err_tlast), int'(m == 9));
    end
    for (int m = 0; m < 16; m++)
      beat(m == 15, m, 1, (m * 256) % 1024, m == 15);
    done_seq();
    chk("err_sticky", int'(o_err_tlast), 1);
    start(3'd0, 4'd2, 1);
    chk("err_clr", int'(o_err_tlast), 0);
    run_blocks(16, 256, 1, 1'b0);

    // Missing tlast at m=15, then abort mid block 1
    start(3'd0, 4'd2, 3);
    for (int m = 0; m < 16; m++)
      beat(1'b0, m, 0, 0, m == 15);
    chk("err_missing", int'(o_err_tlast), 1);
    for (int m = 0; m < 5; m++)
      beat(1'b0, m, 1, (m * 256) % 1024, 1'b0);
    i_abort    = 1'b1;
    i_s_tvalid = 1'b1;
    tick();
    i_abort    = 1'b0;
    i_s_tvalid = 1'b0;
    chk("abort_tready", int'(o_s_tready), 0);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_valid", int'(o_addr_valid), 0);
    chk("abort_err", int'(o_err_tlast), 1);
    repeat (3) begin
      tick();
      chk("abort_rdone", int'(o_run_done), 0);
    end
    start(3'd0, 4'd2, 1);
    chk("restart_err", int'(o_err_tlast), 0);
    run_blocks(16, 256, 1, 1'b0);

    // Start during RUN is ignored; reset mid-run clears outputs
    start(3'd0, 4'd2, 2);
    for (int m = 0; m < 6; m++)
      beat(1'b0, m, 0, 0, 1'b0);
    i_NFFT_sel   = 3'd1;
    i_L_log2     = 4'd5;
    i_num_blocks = 7'd1;
    i_start      = 1'b1;
    beat(1'b0, 6, 0, 0, 1'b0);
    i_start = 1'b0;
    for (int m = 7; m < 16; m++)
      beat(m == 15, m, 0, 0, m == 15);
    for (int m = 0; m < 4; m++)
      beat(1'b0, m, 1, (m * 256) % 1024, 1'b0);
    chk("busy_pre_rst", int'(o_busy), 1);
    i_reset = 1'b1;
    tick();
    zeros("midrst");
    i_reset = 1'b0;
    tick();
    chk("busy_post_rst", int'(o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
